// File: rtl/button_debouncer.sv
// Push-button debouncer: 2-flop synchronizer, agreement counter, registered
// press/release pulses and a saturating press-duration counter.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int DUR_W           = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN,
  output logic             BTN_CLEAN,
  output logic             PRESS,
  output logic             RELEASE,
  output logic [DUR_W-1:0] DURATION
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DUR_W-1:0] DUR_MAX  = '1;

  logic             btn_m;
  logic             btn_s;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             accept;

  // accept fires on the edge that completes DEBOUNCE_CYCLES disagreeing samples
  always_comb begin
    differ = (btn_s != BTN_CLEAN);
    accept = differ && (cnt == CNT_LAST);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= BTN;
      btn_s <= btn_m;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (!differ || accept) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      BTN_CLEAN <= 1'b0;
      PRESS     <= 1'b0;
      RELEASE   <= 1'b0;
    end else begin
      if (accept) begin
        BTN_CLEAN <= btn_s;
      end
      PRESS   <= accept && btn_s;
      RELEASE <= accept && !btn_s;
    end
  end

  // Counts only while the clean level stays high; frozen while low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      DURATION <= '0;
    end else if (accept && btn_s) begin
      DURATION <= DUR_W'(1);
    end else if (BTN_CLEAN && !accept && (DURATION != DUR_MAX)) begin
      DURATION <= DURATION + 1'b1;
    end
  end

endmodule
